// File: rtl/reg_scoreboard_pkg.sv
// Shared scoreboard constants: unit tags and register index width.
// Imported by the entry flop and the scoreboard top.
package scoreboard_pkg;

  localparam int UNIT_W = 2;
  localparam int REG_W  = 5;

  localparam logic [UNIT_W-1:0] UNIT_NONE = 2'd0;
  localparam logic [UNIT_W-1:0] UNIT_LSU  = 2'd1;
  localparam logic [UNIT_W-1:0] UNIT_MUL  = 2'd2;
  localparam logic [UNIT_W-1:0] UNIT_DIV  = 2'd3;

endpackage

// File: rtl/reg_scoreboard_entry.sv
// One tracked register: busy flag plus the unit that owns the write.
// A set in the same cycle as a clear wins.
module sb_entry #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         set_i,
  input  logic         clr_i,
  input  logic [W-1:0] unit_i,
  output logic         busy_o,
  output logic [W-1:0] owner_o
);
  import scoreboard_pkg::*;

  logic         busy_q, busy_d;
  logic [W-1:0] owner_q, owner_d;

  // Next state: issue overrides a same-cycle writeback clear.
  always_comb begin
    busy_d  = busy_q;
    owner_d = owner_q;
    if (set_i) begin
      busy_d  = 1'b1;
      owner_d = unit_i;
    end else if (clr_i) begin
      busy_d  = 1'b0;
    end
  end

  // Busy/owner register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q  <= 1'b0;
      owner_q <= '0;
    end else begin
      busy_q  <= busy_d;
      owner_q <= owner_d;
    end
  end

  assign busy_o  = busy_q;
  assign owner_o = owner_q;

endmodule

// File: rtl/reg_scoreboard.sv
// Long-latency write scoreboard: RAW/WAW stall against pending
// LSU/MUL/DIV destinations, with tagged writeback release.
module reg_scoreboard #(
  parameter int NUM_REGS  = 32,
  parameter int UNIT_W    = 2,
  parameter int WB_BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ID_valid,
  input  logic [4:0]        ID_rs1,
  input  logic [4:0]        ID_rs2,
  input  logic              ID_use_rs1,
  input  logic              ID_use_rs2,
  input  logic [4:0]        ID_rd,
  input  logic              ID_long_op,
  input  logic [UNIT_W-1:0] ID_unit,
  input  logic              ID_Flush_ext,
  input  logic              WB_valid,
  input  logic [4:0]        WB_rd,
  input  logic [UNIT_W-1:0] WB_unit,
  output logic              PCWrite,
  output logic              IF_IDWrite,
  output logic              ID_Flush_hazard,
  output logic [5:0]        pending_cnt,
  output logic [31:0]       stall_cycles
);
  import scoreboard_pkg::*;

  localparam logic BYP = (WB_BYPASS != 0);

  logic [NUM_REGS-1:0]             busy;
  logic [NUM_REGS-1:0][UNIT_W-1:0] owner;
  logic [NUM_REGS-1:0]             wb_hit;
  logic [NUM_REGS-1:0]             bview;
  logic [NUM_REGS-1:0]             clr;
  logic [NUM_REGS-1:0]             set;

  logic raw, waw, hazard, issue, dec;

  logic [5:0]  pend_q, pend_d;
  logic [31:0] stall_q, stall_d;

  assign busy[0]  = 1'b0;
  assign owner[0] = '0;
  assign set[0]   = 1'b0;

  genvar r;
  generate
    for (r = 1; r < NUM_REGS; r++) begin : g_ent
      assign set[r] = issue && (ID_rd == REG_W'(r));
      sb_entry #(.W(UNIT_W)) u_ent (
        .clk     (clk),
        .rst     (rst),
        .set_i   (set[r]),
        .clr_i   (clr[r]),
        .unit_i  (ID_unit),
        .busy_o  (busy[r]),
        .owner_o (owner[r])
      );
    end
  endgenerate

  // Writeback match per register and the bypass-adjusted busy view.
  always_comb begin
    wb_hit = '0;
    clr    = '0;
    bview  = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      wb_hit[i] = WB_valid && (WB_rd == REG_W'(i))
                  && (WB_unit == owner[i]);
      clr[i]    = busy[i] & wb_hit[i];
      bview[i]  = busy[i] & ~(BYP & wb_hit[i]);
    end
  end

  // Hazard compare; an external flush suppresses the stall.
  always_comb begin
    raw    = ID_valid & ((ID_use_rs1 & bview[ID_rs1])
                       | (ID_use_rs2 & bview[ID_rs2]));
    waw    = ID_valid & ID_long_op & bview[ID_rd];
    hazard = (raw | waw) & ~ID_Flush_ext;
    issue  = ID_valid & ID_long_op & (ID_rd != 5'd0)
             & ~hazard & ~ID_Flush_ext;
    dec    = |clr;
  end

  // Counter next state: pending +issue -clear, stall saturating.
  always_comb begin
    pend_d  = pend_q + {5'd0, issue} - {5'd0, dec};
    stall_d = stall_q;
    if (hazard && (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q  <= '0;
      stall_q <= '0;
    end else begin
      pend_q  <= pend_d;
      stall_q <= stall_d;
    end
  end

  assign PCWrite         = ~hazard;
  assign IF_IDWrite      = ~hazard;
  assign ID_Flush_hazard = hazard;
  assign pending_cnt     = pend_q;
  assign stall_cycles    = stall_q;

endmodule

// File: doc/reg_scoreboard.md
# reg_scoreboard

Register-file scoreboard for the 5-stage pipeline. It records which architectural registers have an outstanding long-latency write: loads with memory wait states, multiply, and divide. It clears those entries when the owning unit writes back. It compares each ID-stage instruction against the pending set and produces the same stall/bubble controls the load-use check drives. ALU results are forwarded and never tracked.

## Interface
- NUM_REGS, 32: architectural registers; x0 is never tracked.
- UNIT_W, 2: width of the unit tag (0 = none, 1 = LSU, 2 = MUL, 3 = DIV).
- WB_BYPASS, 1: when 1, a writeback in the same cycle releases a stall in that cycle.
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- ID_valid  in  1  ID holds a real instruction.
- ID_rs1, ID_rs2  in  5 each  source register indices.
- ID_use_rs1, ID_use_rs2  in  1 each  the instruction reads that source.
- ID_rd  in  5  destination register index.
- ID_long_op  in  1  destination is written by a tracked unit.
- ID_unit  in  UNIT_W  tracked unit that will write ID_rd.
- ID_Flush_ext  in  1  branch/jump squash of the ID instruction (from EX).
- WB_valid  in  1  a tracked unit completes a write this cycle.
- WB_rd  in  5  register being written back.
- WB_unit  in  UNIT_W  completing unit.
- PCWrite  out  1  0 = hold PC.
- IF_IDWrite  out  1  0 = hold IF/ID register.
- ID_Flush_hazard  out  1  1 = inject a bubble into ID/EX.
- pending_cnt  out  6  number of tracked registers currently busy.
- stall_cycles  out  32  saturating count of cycles with the hazard stall asserted.

## Operation
- State: busy[31:1], owner[31:1][UNIT_W-1:0], pending_cnt, stall_cycles. Reset clears all of them to 0.
- The "busy view" of register r is busy[r] & ~(WB_BYPASS & WB_valid & WB_rd==r & WB_unit==owner[r]). r==0 is always not busy.
- raw = ID_valid & ((ID_use_rs1 & busy view of rs1) | (ID_use_rs2 & busy view of rs2)).
- waw = ID_valid & ID_long_op & busy view of ID_rd. This prevents an older, slower unit from overwriting a younger result.
- hazard = (raw | waw) & ~ID_Flush_ext. When a flush is present it takes priority and no stall is raised.
- Outputs, combinational from state plus inputs:
  - PCWrite = ~hazard.
  - IF_IDWrite = ~hazard.
  - ID_Flush_hazard = hazard.
- issue = ID_valid & ID_long_op & ID_rd!=0 & ~hazard & ~ID_Flush_ext.
- Writeback: if WB_valid, busy[WB_rd], and owner[WB_rd]==WB_unit, then clear busy[WB_rd]. Any other writeback is a stale or untracked write and is ignored.
- Issue: set busy[ID_rd] and owner[ID_rd] = ID_unit.
- Issue and writeback on the same register in the same cycle: the issue wins. busy stays 1 and owner takes the new unit. This case occurs only with WB_BYPASS=1.
- pending_cnt changes by +1 on issue and −1 on an accepted clear. Simultaneous issue and clear of different registers leaves it unchanged; the same-register case gives a net change of 0.
- stall_cycles increments each cycle hazard=1 and saturates at 0xFFFF_FFFF.
- rst asserted mid-operation drops every busy bit and the counters in the same edge. Outstanding writebacks that arrive afterwards are ignored because busy is 0.

## Timing
- Check latency: 0 cycles. Outputs are valid in the same cycle as the ID inputs.
- Issue and clear take effect at the next rising edge.
- With WB_BYPASS=0, a dependent instruction stalls through the writeback cycle and proceeds one cycle later.
- With WB_BYPASS=1, it proceeds in the writeback cycle, relying on write-first register-file forwarding.
- Reset values: PCWrite=1, IF_IDWrite=1, ID_Flush_hazard=0, pending_cnt=0, stall_cycles=0.
- No handshake backpressure exists toward the units: WB_valid is accepted every cycle, one write per cycle.

## Structure
- Shared package scoreboard_pkg holds:
  - UNIT_NONE/UNIT_LSU/UNIT_MUL/UNIT_DIV constants.
  - The UNIT_W localparam.
  - The reg index width (5).
- One sub-module is natural: sb_entry, a per-register busy/owner flop pair with its set/clear logic. It is instantiated 31 times by a generate loop.
- Top level contains the hazard compare, the counters, and the output drive.

## Test plan
- Reset then idle, ID_valid=1, rs1=5 → PCWrite=1, IF_IDWrite=1, ID_Flush_hazard=0, pending_cnt=0.
- Issue a MUL to x5. Next cycle, ID reads rs1=5 → hazard=1 each cycle. WB_valid, WB_rd=5, WB_unit=MUL:
  - WB_BYPASS=1 → stall drops in the same cycle.
  - WB_BYPASS=0 → stall drops one cycle later.
  - In both cases stall_cycles matches the stalled cycle count.
- Issue a DIV to x7. The next instruction is a LSU load to x7 → waw stall until the DIV writeback, then the load issues and owner becomes LSU. A late WB from DIV to x7 is ignored, and pending_cnt stays 1.
- Hazard with ID_Flush_ext=1 → ID_Flush_hazard=0 and PCWrite=1. No busy bit is set for the flushed instruction.
- Issue to x0 and a writeback to x0 → pending_cnt stays 0 and no stall on rs1=0.
- Three registers busy, assert rst for one cycle → pending_cnt=0, all stalls clear. Subsequent WB_valid to those registers has no effect.
